// File: rtl/prescaled_updown_counter.sv
// Up/down counter stepped by a single-clock prescaler tick, with parallel load,
// wrap or saturate at the bounds, and a one-cycle terminal-count pulse.
module prescaled_updown_counter #(
  parameter int WIDTH = 4,
  parameter int DIV   = 50_000_000,
  parameter int PW    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             tc
);

  localparam logic [PW-1:0]    P_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] Q_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] Q_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [PW-1:0]    p_reg, p_next;
  logic             tick_reg, tick_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             tc_reg, tc_next;
  logic             at_max, at_min;

  // Prescaler: a paused count keeps its phase, so the next tick lands where it would have.
  always_comb begin
    p_next    = p_reg;
    tick_next = 1'b0;
    if (en) begin
      if (p_reg == P_LAST) begin
        p_next    = '0;
        tick_next = 1'b1;
      end else begin
        p_next = p_reg + 1'b1;
      end
    end
  end

  assign at_max = (q_reg == Q_MAX);
  assign at_min = (q_reg == '0);

  // A load on a tick cycle swallows that tick; direction and mode only matter on a tick.
  always_comb begin
    q_next  = q_reg;
    tc_next = 1'b0;
    if (load) begin
      q_next = d;
    end else if (tick_reg) begin
      if (up) begin
        tc_next = at_max;
        if (!(at_max && sat)) begin
          q_next = q_reg + Q_ONE;
        end
      end else begin
        tc_next = at_min;
        if (!(at_min && sat)) begin
          q_next = q_reg - Q_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_reg    <= '0;
      tick_reg <= 1'b0;
      q_reg    <= '0;
      tc_reg   <= 1'b0;
    end else begin
      p_reg    <= p_next;
      tick_reg <= tick_next;
      q_reg    <= q_next;
      tc_reg   <= tc_next;
    end
  end

  assign q    = q_reg;
  assign tick = tick_reg;
  assign tc   = tc_reg;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Runs a DIV=4 and a DIV=1 counter side by side from shared stimulus, checking both
// every cycle against an arithmetic model, plus hand-computed scenario expectations.
module tb_prescaled_updown_counter;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0, up = 1'b1, sat = 1'b0, load = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] q4, q1;
  logic tick4, tick1, tc4, tc1;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  prescaled_updown_counter #(.WIDTH(W), .DIV(4), .PW(8)) dut4 (
    .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load), .d(d),
    .q(q4), .tick(tick4), .tc(tc4)
  );

  prescaled_updown_counter #(.WIDTH(W), .DIV(1), .PW(8)) dut1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load), .d(d),
    .q(q1), .tick(tick1), .tc(tc1)
  );

  typedef struct {
    int p;
    bit tick;
    int q;
    bit tc;
  } mstate_t;

  mstate_t m4, m1;

  function automatic mstate_t model_next(mstate_t s, int div, bit en_i, bit up_i,
                                         bit sat_i, bit load_i, int d_i);
    mstate_t n = s;
    if (en_i) begin
      n.tick = (s.p == div - 1);
      n.p    = (s.p + 1) % div;
    end else begin
      n.tick = 1'b0;
    end
    if (load_i) begin
      n.q  = d_i;
      n.tc = 1'b0;
    end else if (s.tick) begin
      if (up_i) begin
        n.tc = (s.q == MAXV);
        n.q  = (s.q == MAXV && sat_i) ? s.q : (s.q + 1) % (MAXV + 1);
      end else begin
        n.tc = (s.q == 0);
        n.q  = (s.q == 0 && sat_i) ? 0 : (s.q + MAXV) % (MAXV + 1);
      end
    end else begin
      n.tc = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m4 <= '{0, 1'b0, 0, 1'b0};
      m1 <= '{0, 1'b0, 0, 1'b0};
    end else begin
      m4 <= model_next(m4, 4, en, up, sat, load, int'(d));
      m1 <= model_next(m1, 1, en, up, sat, load, int'(d));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("q_div4", int'(q4), m4.q);
      check("tick_div4", int'(tick4), int'(m4.tick));
      check("tc_div4", int'(tc4), int'(m4.tc));
      check("q_div1", int'(q1), m1.q);
      check("tick_div1", int'(tick1), int'(m1.tick));
      check("tc_div1", int'(tc1), int'(m1.tc));
    end
  end

  task automatic wait_tick4();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick4) begin
        ok = 1'b1;
        break;
      end
    end
    check("tick4_timeout", int'(ok), 1);
  endtask

  initial begin
    int cnt4, cnt1;
    logic [W-1:0] saved;

    // Reset state
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("reset_q", int'(q4), 0);
    check("reset_tick", int'(tick4), 0);
    check("reset_tc", int'(tc4), 0);
    reset = 1'b0;

    // Scenario 1: free-running count up with wrap
    en = 1'b1; up = 1'b1; sat = 1'b0;
    cnt4 = 0; cnt1 = 0;
    for (int i = 0; i < 72; i++) begin
      @(negedge clk);
      if (tc4) cnt4++;
      if (tc1) cnt1++;
      if (i == 1) check("div1_first_step", int'(q1), 1);
      if (i == 3) begin
        check("first_tick_at_div", int'(tick4), 1);
        check("q_before_first_step", int'(q4), 0);
      end
      if (i == 4) check("first_step_at_div_plus1", int'(q4), 1);
    end
    $display("scenario1: q4=%0d tc4_pulses=%0d q1=%0d tc1_pulses=%0d", q4, cnt4, q1, cnt1);
    check("s1_q4_end", int'(q4), 1);
    check("s1_tc4_count", cnt4, 1);
    check("s1_q1_end", int'(q1), 7);
    check("s1_tc1_count", cnt1, 4);

    // Scenario 2: load E, saturate upward
    load = 1'b1; d = 4'hE; sat = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("s2_load_e", int'(q4), 14);
    repeat (20) @(negedge clk);
    $display("scenario2: q4=%0d q1=%0d", q4, q1);
    check("s2_q4_sat", int'(q4), 15);
    check("s2_q1_sat", int'(q1), 15);

    // Scenario 3: count down through 0 with wrap
    wait_tick4();
    @(negedge clk);
    load = 1'b1; d = 4'd1; up = 1'b0; sat = 1'b0;
    @(negedge clk);
    load = 1'b0;
    check("s3_load_1", int'(q4), 1);
    repeat (3) @(negedge clk);
    check("s3_q_zero", int'(q4), 0);
    check("s3_tc_low_at_1to0", int'(tc4), 0);
    repeat (4) @(negedge clk);
    $display("scenario3: q4=%0d tc4=%0d", q4, tc4);
    check("s3_q_wrap_f", int'(q4), 15);
    check("s3_tc_high_at_0tof", int'(tc4), 1);

    // Scenario 5: load coinciding with a tick
    up = 1'b1;
    wait_tick4();
    load = 1'b1; d = 4'd7;
    @(negedge clk);
    load = 1'b0;
    $display("scenario5: q4=%0d tc4=%0d", q4, tc4);
    check("s5_load_on_tick", int'(q4), 7);
    check("s5_tc_after_load", int'(tc4), 0);

    // Scenario 4: pause with prescaler at its last count
    wait_tick4();
    repeat (3) @(negedge clk);
    en = 1'b0;
    saved = q4;
    repeat (10) @(negedge clk);
    check("s4_q_held", int'(q4), int'(saved));
    check("s4_no_tick_paused", int'(tick4), 0);
    en = 1'b1;
    @(negedge clk);
    $display("scenario4: tick4=%0d after one enabled cycle", tick4);
    check("s4_tick_after_resume", int'(tick4), 1);

    // Scenario 6: asynchronous reset between edges
    en = 1'b0; load = 1'b1; d = 4'd9;
    @(negedge clk);
    load = 1'b0;
    check("s6_load_9", int'(q4), 9);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    $display("scenario6: q4=%0d tick4=%0d tc4=%0d q1=%0d", q4, tick4, tc4, q1);
    check("s6_async_q4", int'(q4), 0);
    check("s6_async_tick", int'(tick4), 0);
    check("s6_async_tc", int'(tc4), 0);
    check("s6_async_q1", int'(q1), 0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 9) != 0);
      up    = 1'($urandom_range(0, 1));
      sat   = 1'($urandom_range(0, 1));
      load  = ($urandom_range(0, 19) == 0);
      d     = W'($urandom);
    end
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    repeat (4) @(negedge clk);
    chk_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
